// File: rtl/dilithium_mem_pkg.sv
// Shared types and constants for the polynomial-memory access blocks.
package dilithium_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int POLY_WORDS     = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO. Reset empties it; stored words are not cleared.
module stream_fifo
  import dilithium_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int CW    = cnt_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_pop_s  = pop_i && (count_q != '0);
  assign do_push_s = push_i && (count_q != CW'(DEPTH));

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// Reads len consecutive RAM words (wrapping) and streams them out with valid/ready.
// The one-cycle RAM latency is hidden by a credit-limited output FIFO.
module ram_stream_reader
  import dilithium_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int OW = CW + 1;

  rd_state_t       state_q, state_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            addr_new_q, addr_new_d;   // ram_addr holds an address not yet read
  logic            tag_q;                    // ram_dout carries a requested word
  logic [AW:0]     issued_q, issued_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     pop_cnt_q, pop_cnt_d;
  logic            busy_q, busy_d;

  logic [DATA_WIDTH-1:0] fifo_rdata_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic [OW-1:0]         occ_s;
  logic                  credit_ok_s;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_q),
    .wdata_i (ram_dout),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign pop_s = m_valid && m_ready;

  // Space left after counting words buffered plus reads still in the RAM pipe.
  assign occ_s = OW'(fifo_count_s) + OW'(tag_q) + OW'(addr_new_q) - OW'(pop_s);
  assign credit_ok_s = (occ_s < OW'(FIFO_DEPTH));

  // Next-state, address and counter logic.
  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    addr_new_d = 1'b0;
    issued_d   = issued_q;
    len_d      = len_q;
    busy_d     = busy_q;
    if (pop_s) begin
      pop_cnt_d = pop_cnt_q + (AW+1)'(1);
    end else begin
      pop_cnt_d = pop_cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len;
          busy_d    = 1'b1;
          pop_cnt_d = '0;
          if (len != '0) begin
            state_d    = ISSUE;
            ram_addr_d = base_addr;
            addr_new_d = 1'b1;
            issued_d   = (AW+1)'(1);
          end else begin
            state_d = FINISH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issued_q == len_q) begin
          state_d = DRAIN;
        end else if (credit_ok_s) begin
          ram_addr_d = ram_addr_q + AW'(1);
          addr_new_d = 1'b1;
          issued_d   = issued_q + (AW+1)'(1);
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        // Leave as the final word is handed over so done follows it directly.
        if (!addr_new_q && !tag_q &&
            (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s))) begin
          state_d = FINISH;
          busy_d  = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset also drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      addr_new_q <= 1'b0;
      tag_q      <= 1'b0;
      issued_q   <= '0;
      len_q      <= '0;
      pop_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      addr_new_q <= addr_new_d;
      tag_q      <= addr_new_q;
      issued_q   <= issued_d;
      len_q      <= len_d;
      pop_cnt_q  <= pop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = (state_q == FINISH);
  assign ram_addr = ram_addr_q;
  assign ram_we   = 1'b0;
  assign ram_din  = '0;
  assign m_valid  = !fifo_empty_s;
  assign m_data   = fifo_empty_s ? '0 : fifo_rdata_s;
  assign m_last   = m_valid && (pop_cnt_q == (len_q - (AW+1)'(1)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a word scoreboard.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  base_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic [6:0]  ram_addr;
  logic        ram_we;
  logic [63:0] ram_din;
  logic [63:0] ram_dout;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic        m_ready;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem [128];

  int checks = 0;
  int errors = 0;
  int t;
  int first_valid_t, last_hs_t, done_t, busy_fall_t, hs_cnt, valid_seen;
  logic [6:0]  addr_t1;
  logic        busy_t1;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  ram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe outputs just after the falling edge of the current cycle.
  task automatic monitor();
    exp_t e;
    if (prev_stall) begin
      chk("hold_data", m_data, prev_data);
      chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
    end
    if (m_valid) valid_seen++;
    if (m_valid && first_valid_t < 0) first_valid_t = t;
    if (t == 1) begin
      addr_t1 = ram_addr;
      busy_t1 = busy;
    end
    if (t >= 1 && !busy && busy_fall_t < 0) busy_fall_t = t;
    if (t >= 1 && done && done_t < 0) done_t = t;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("extra_word", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("word_data", m_data, e.d);
        chk("word_last", {63'd0, m_last}, {63'd0, e.l});
      end
      hs_cnt++;
      last_hs_t = t;
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic do_cycle(input logic st, input logic rdy);
    @(negedge clk);
    start   = st;
    m_ready = rdy;
    #1;
    monitor();
  endtask

  task automatic begin_xfer(input logic [6:0] b, input logic [7:0] l);
    exp_t e;
    first_valid_t = -1; last_hs_t = -1; done_t = -1; busy_fall_t = -1;
    hs_cnt = 0; valid_seen = 0;
    for (int i = 0; i < int'(l); i++) begin
      e.d = 64'h1000 + 64'((int'(b) + i) % 128);
      e.l = (i == int'(l) - 1);
      sb.push_back(e);
    end
    base_addr = b;
    len = l;
    t = 0;
    do_cycle(1'b1, 1'b1);
  endtask

  task automatic run_xfer(input logic [6:0] b, input logic [7:0] l, input bit rnd,
                          input int budget, input int busy_start_t);
    logic r;
    begin_xfer(b, l);
    while (done_t < 0 && t < budget) begin
      t++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (t == busy_start_t) begin
        base_addr = 7'd3;
        len = 8'd5;
        do_cycle(1'b1, r);
      end else begin
        do_cycle(1'b0, r);
      end
    end
    t++;
    do_cycle(1'b0, 1'b1);
    chk("xfer_done_seen", {63'd0, done_t >= 0}, 64'd1);
    chk("xfer_word_count", 64'(hs_cnt), 64'(l));
    chk("xfer_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'h1000 + 64'(i);
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 7'd0; len = 8'd0;
    t = -10;
    repeat (3) do_cycle(1'b0, 1'b0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_last", {63'd0, m_last}, 64'd0);
    chk("rst_addr", {57'd0, ram_addr}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("ram_we_zero", {63'd0, ram_we}, 64'd0);
    chk("ram_din_zero", ram_din, 64'd0);
    rst = 1'b0;
    do_cycle(1'b0, 1'b1);

    // Basic transfer and its cycle timing.
    run_xfer(7'd5, 8'd8, 1'b0, 60, -1);
    chk("basic_addr_c1", {57'd0, addr_t1}, 64'd5);
    chk("basic_first_valid", 64'(first_valid_t), 64'd3);
    chk("basic_last_hs", 64'(last_hs_t), 64'd10);
    chk("basic_done", 64'(done_t), 64'd11);
    chk("basic_busy_fall", 64'(busy_fall_t), 64'd11);

    // Address wrap.
    run_xfer(7'd126, 8'd4, 1'b0, 60, -1);

    // Full memory under random backpressure, with a start pulse while busy.
    run_xfer(7'd37, 8'd128, 1'b1, 2000, 20);

    // Zero-length transfer.
    run_xfer(7'd9, 8'd0, 1'b0, 20, -1);
    chk("len0_done", 64'(done_t), 64'd1);
    chk("len0_busy_c1", {63'd0, busy_t1}, 64'd1);
    chk("len0_busy_fall", 64'(busy_fall_t), 64'd2);
    chk("len0_no_valid", 64'(valid_seen), 64'd0);

    // Reset in the middle of a transfer.
    begin_xfer(7'd0, 8'd10);
    while (hs_cnt < 3 && t < 40) begin
      t++;
      do_cycle(1'b0, 1'b1);
    end
    chk("rst_mid_words", 64'(hs_cnt), 64'd3);
    rst = 1'b1;
    t++;
    do_cycle(1'b0, 1'b0);
    rst = 1'b0;
    t++;
    do_cycle(1'b0, 1'b1);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_mid_last", {63'd0, m_last}, 64'd0);
    chk("rst_mid_addr", {57'd0, ram_addr}, 64'd0);
    chk("rst_mid_data", m_data, 64'd0);
    chk("rst_mid_no_done", {63'd0, done_t >= 0}, 64'd0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b1);
      chk("rst_idle_valid", {63'd0, m_valid}, 64'd0);
    end
    run_xfer(7'd0, 8'd2, 1'b0, 40, -1);

    // Sustained throughput over the whole memory.
    run_xfer(7'd0, 8'd128, 1'b0, 400, -1);
    chk("full_last_hs", 64'(last_hs_t), 64'd130);
    chk("full_done", 64'(done_t), 64'd131);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
